// File: rtl/regfile_write_queue.sv
// Write-side staging FIFO for the register file: queues (addr, data) writes, drains
// one per cycle as a registered one-hot active-low strobe, and offers a pending-write lookup.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       rf_stall,
    output logic [(1<<AW)-1:0]         rf_write_n,
    output logic [DW-1:0]              rf_data,
    input  logic [AW-1:0]              chk_addr,
    output logic                       chk_hit,
    output logic [DW-1:0]              chk_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;

    logic [AW-1:0] mem_addr_r [DEPTH];
    logic [DW-1:0] mem_data_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] out_addr_r;
    logic [NR-1:0] rf_write_n_r;
    logic [DW-1:0] rf_data_r;

    logic          push_s;
    logic          pop_s;
    logic          hit_s;
    logic [DW-1:0] hit_data_s;
    logic [PW-1:0] idx_s;
    logic          match_s;

    function automatic logic [NR-1:0] strobe_n(input logic [AW-1:0] a);
        logic [NR-1:0] s;
        s    = {NR{1'b1}};
        s[a] = 1'b0;
        return s;
    endfunction

    // Full check uses the registered count only, so a same-cycle pop never opens a slot.
    assign in_ready = (count_r < CW'(DEPTH)) && !reset;
    assign push_s   = in_valid && in_ready;
    assign pop_s    = (count_r != {CW{1'b0}}) && !rf_stall;

    assign rf_write_n = rf_write_n_r;
    assign rf_data    = rf_data_r;
    assign count      = count_r;
    assign empty      = (count_r == {CW{1'b0}});
    assign chk_hit    = hit_s;
    assign chk_data   = hit_data_s;

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_addr_r[tail_r] <= in_addr;
            mem_data_r[tail_r] <= in_data;
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= {PW{1'b0}};
            tail_r       <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            out_addr_r   <= {AW{1'b0}};
            rf_write_n_r <= {NR{1'b1}};
            rf_data_r    <= {DW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s) begin
                head_r       <= head_r + PW'(1);
                out_addr_r   <= mem_addr_r[head_r];
                rf_write_n_r <= strobe_n(mem_addr_r[head_r]);
                rf_data_r    <= mem_data_r[head_r];
            end else begin
                rf_write_n_r <= {NR{1'b1}};
            end
        end
    end

    // Lookup: output stage first, then oldest to youngest queued entry, so the youngest wins.
    always_comb begin
        hit_s      = (rf_write_n_r != {NR{1'b1}}) && (out_addr_r == chk_addr);
        hit_data_s = hit_s ? rf_data_r : {DW{1'b0}};
        idx_s      = head_r;
        match_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = head_r + PW'(i);
            match_s    = (CW'(i) < count_r) && (mem_addr_r[idx_s] == chk_addr);
            hit_s      = hit_s | match_s;
            hit_data_s = match_s ? mem_data_r[idx_s] : hit_data_s;
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue with a negedge register-file model.
module tb_regfile_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_addr;
    logic [15:0] in_data;
    logic        rf_stall;
    logic [7:0]  rf_write_n;
    logic [15:0] rf_data;
    logic [2:0]  chk_addr;
    logic        chk_hit;
    logic [15:0] chk_data;
    logic [2:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;
    int multi_low = 0;

    logic [15:0] rf_model [8];
    logic [2:0]  log_a [$];
    logic [15:0] log_d [$];

    regfile_write_queue #(.DEPTH(4), .AW(3), .DW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .rf_stall(rf_stall),
        .rf_write_n(rf_write_n), .rf_data(rf_data), .chk_addr(chk_addr),
        .chk_hit(chk_hit), .chk_data(chk_data), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Register file: slices capture on the negedge while their strobe is low.
    always @(negedge clk) begin
        int lows;
        logic [2:0] a;
        lows = 0;
        a = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!rf_write_n[i]) begin
                lows++;
                a = 3'(i);
                rf_model[i] = rf_data;
            end
        end
        if (lows > 1) multi_low++;
        if (lows == 1) begin
            log_a.push_back(a);
            log_d.push_back(rf_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic check_log(input string tag, input int n, input logic [15:0] base);
        check({tag, "_len"}, log_a.size(), n);
        for (int j = 0; j < n; j++) begin
            if (j < log_a.size()) begin
                check({tag, "_addr"}, log_a[j], 32'(j % 8));
                check({tag, "_data"}, log_d[j], 32'(base + 16'(j)));
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = 3'd0; in_data = 16'd0;
        rf_stall = 1'b0; chk_addr = 3'd0;
        for (int i = 0; i < 8; i++) rf_model[i] = 16'd0;

        // Reset state
        tick(); tick();
        check("rst_ready", in_ready, 0);
        check("rst_strobe", rf_write_n, 32'hFF);
        check("rst_data", rf_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_hit", chk_hit, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // Single push R3=BEEF, strobe only after edge 2
        push(3'd3, 16'hBEEF);
        check("single_e1_strobe", rf_write_n, 32'hFF);
        check("single_e1_count", count, 1);
        tick();
        check("single_e2_strobe", rf_write_n, 32'hF7);
        check("single_e2_data", rf_data, 32'hBEEF);
        tick();
        check("single_e3_strobe", rf_write_n, 32'hFF);
        check("single_rf3", rf_model[3], 32'hBEEF);

        // Fill with stall, fifth request held
        clear_log();
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(3'(i), 16'h1000 + 16'(i));
        check("fill_count", count, 4);
        check("fill_ready", in_ready, 0);
        in_valid = 1'b1; in_addr = 3'd4; in_data = 16'h1004;
        tick(); tick();
        check("fill_held_count", count, 4);
        check("fill_held_strobe", rf_write_n, 32'hFF);
        rf_stall = 1'b0;
        tick();
        check("fill_rel_count", count, 3);
        check("fill_rel_strobe", rf_write_n, 32'hFE);
        tick();
        in_valid = 1'b0;
        check("fill_pp_count", count, 3);
        for (int i = 0; i < 6; i++) tick();
        check("fill_empty", empty, 1);
        check_log("fill", 5, 16'h1000);

        // Forwarding: youngest pending write wins, output stage included
        rf_stall = 1'b1;
        push(3'd5, 16'h1111);
        push(3'd5, 16'h2222);
        chk_addr = 3'd5;
        #1;
        check("fwd_hit", chk_hit, 1);
        check("fwd_data", chk_data, 32'h2222);
        chk_addr = 3'd6;
        #1;
        check("fwd_miss_hit", chk_hit, 0);
        check("fwd_miss_data", chk_data, 0);
        chk_addr = 3'd5;
        rf_stall = 1'b0;
        tick();
        check("fwd_d1_data", chk_data, 32'h2222);
        tick();
        check("fwd_out_hit", chk_hit, 1);
        check("fwd_out_data", chk_data, 32'h2222);
        tick();
        check("fwd_done_hit", chk_hit, 0);
        check("fwd_done_data", chk_data, 0);
        check("fwd_rf5", rf_model[5], 32'h2222);

        // Concurrent push/pop at count=2, pointers wrapping
        rf_stall = 1'b1;
        push(3'd0, 16'h2000);
        push(3'd1, 16'h2001);
        clear_log();
        rf_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_addr  = 3'((k + 2) % 8);
            in_data  = 16'h2002 + 16'(k);
            tick();
            check("cc_count", count, 2);
            check("cc_strobe", rf_write_n, 32'(~(8'd1 << (k % 8)) & 8'hFF));
            check("cc_data", rf_data, 32'(16'h2000 + 16'(k)));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_log("cc", 12, 16'h2000);

        // Reset mid-drain
        rf_stall = 1'b1;
        push(3'd1, 16'h3001);
        push(3'd2, 16'h3002);
        push(3'd6, 16'h3006);
        rf_stall = 1'b0;
        tick();
        check("mid_strobe", rf_write_n, 32'hFD);
        check("mid_count", count, 2);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 0);
        tick();
        check("mid_rst_strobe", rf_write_n, 32'hFF);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        reset = 1'b0;
        #1;
        check("mid_post_ready", in_ready, 1);
        clear_log();
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_strobes", log_a.size(), 0);
        check("mid_final_strobe", rf_write_n, 32'hFF);

        check("onehot_strobes", multi_low, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
